// File: rtl/subtractor_xbit_bitserial_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor and the master side is the requester.
interface subtractor_xbit_bitserial_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_num_a;
  logic [DATA_WIDTH-1:0] i_num_b;
  logic                  i_brw;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_res;
  logic                  o_brw;
  logic                  o_ovf;

  modport slave (
    input  i_valid, i_num_a, i_num_b, i_brw, i_ready,
    output o_ready, o_valid, o_res, o_brw, o_ovf
  );

  modport master (
    output i_valid, i_num_a, i_num_b, i_brw, i_ready,
    input  o_ready, o_valid, o_res, o_brw, o_ovf
  );
endinterface

// File: rtl/subtractor_xbit_bitserial.sv
// Bit-serial two's-complement subtractor: res = a - b - brw, one bit per clock, LSB first.
// Define SUBTRACTOR_XBIT_BITSERIAL_OVF_EN to build the signed-overflow flag; otherwise o_ovf is tied 0.
module subtractor_xbit_bitserial #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  subtractor_xbit_bitserial_if.slave   bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  carry_q;
  logic [DATA_WIDTH-1:0] a_sr;
  logic [DATA_WIDTH-1:0] nb_sr;
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] res_nxt;
  logic                  brw_q;
  logic [1:0]            fa;
  logic                  accept;
  logic                  last_bit;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    full_add = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

  assign accept   = bus.i_valid & ready_q;
  assign last_bit = (state_q == BUSY) && (cnt_q == LAST_BIT);

  always_comb begin
    fa                      = full_add(a_sr[0], nb_sr[0], carry_q);
    res_nxt                 = res_q >> 1;
    res_nxt[DATA_WIDTH-1]   = fa[0];
  end

  // Control and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      brw_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            carry_q <= ~bus.i_brw;
            cnt_q   <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            ready_q <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          res_q   <= res_nxt;
          carry_q <= fa[1];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            brw_q   <= ~fa[1];
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Operand shift registers carry no reset: they are always reloaded on accept.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      a_sr  <= bus.i_num_a;
      nb_sr <= ~bus.i_num_b;
    end else if (state_q == BUSY) begin
      a_sr  <= a_sr >> 1;
      nb_sr <= nb_sr >> 1;
    end
  end

`ifdef SUBTRACTOR_XBIT_BITSERIAL_OVF_EN
  logic ovf_q;

  // carry_q holds the carry into the MSB while the last bit is processed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= carry_q ^ fa[1];
    end
  end

  assign bus.o_ovf = ovf_q;
`else
  assign bus.o_ovf = 1'b0;
`endif

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_res   = res_q;
  assign bus.o_brw   = brw_q;

endmodule
